// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tags at dispatch, captures writeback by tag, retires the
// head in program order. Optional same-cycle writeback-to-lookup bypass under ROB_WB_BYPASS_EN.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE     = 18,
    parameter int unsigned ROB_IDX_SIZE = 5,
    parameter int unsigned REG_SIZE     = 64,
    parameter int unsigned GPR_IDX_SIZE = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_alloc_valid,
    input  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx,
    input  logic                    in_alloc_set_nzcv,
    output logic                    out_alloc_ready,
    output logic [ROB_IDX_SIZE-1:0] out_rob_next_free_index,
    input  logic                    in_wb_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_wb_rob_index,
    input  logic [REG_SIZE-1:0]     in_wb_value,
    input  logic [3:0]              in_wb_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_rd_rob_index,
    output logic                    out_rd_done,
    output logic [REG_SIZE-1:0]     out_rd_value,
    output logic                    out_commit_valid,
    output logic [ROB_IDX_SIZE-1:0] out_commit_rob_index,
    output logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx,
    output logic [REG_SIZE-1:0]     out_commit_value,
    output logic                    out_commit_has_nzcv,
    output logic [3:0]              out_commit_nzcv,
    output logic                    out_empty,
    output logic [ROB_IDX_SIZE:0]   out_count
);

    localparam logic [ROB_IDX_SIZE-1:0] LastIdx   = ROB_IDX_SIZE'(ROB_SIZE - 1);
    localparam logic [ROB_IDX_SIZE:0]   FullCount = (ROB_IDX_SIZE + 1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0]     busy_q, busy_d, done_q, done_d, set_nzcv_q, set_nzcv_d;
    logic [GPR_IDX_SIZE-1:0] gpr_q   [ROB_SIZE];
    logic [GPR_IDX_SIZE-1:0] gpr_d   [ROB_SIZE];
    logic [REG_SIZE-1:0]     value_q [ROB_SIZE];
    logic [REG_SIZE-1:0]     value_d [ROB_SIZE];
    logic [3:0]              nzcv_q  [ROB_SIZE];
    logic [3:0]              nzcv_d  [ROB_SIZE];
    logic [ROB_IDX_SIZE-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_IDX_SIZE:0]   count_q, count_d;

    logic alloc_fire, wb_in_range, wb_ok, rd_in_range;

    function automatic logic [ROB_IDX_SIZE-1:0] wrap_inc(input logic [ROB_IDX_SIZE-1:0] p);
        return (p == LastIdx) ? '0 : p + ROB_IDX_SIZE'(1);
    endfunction

    assign out_alloc_ready = (count_q != FullCount);
    assign alloc_fire      = in_alloc_valid && out_alloc_ready;
    assign wb_in_range     = (32'(in_wb_rob_index) < ROB_SIZE);
    assign wb_ok           = in_wb_valid && wb_in_range && busy_q[in_wb_rob_index]
                             && !done_q[in_wb_rob_index];
    assign rd_in_range     = (32'(in_rd_rob_index) < ROB_SIZE);

    assign out_rob_next_free_index = tail_q;
    assign out_empty               = (count_q == '0);
    assign out_count               = count_q;
    assign out_commit_valid        = busy_q[head_q] && done_q[head_q];
    assign out_commit_rob_index    = head_q;

    // Payload outputs are zeroed when nothing retires so the regfile never sees stale data.
    always_comb begin
        out_commit_gpr_idx  = '0;
        out_commit_value    = '0;
        out_commit_has_nzcv = 1'b0;
        out_commit_nzcv     = '0;
        if (out_commit_valid) begin
            out_commit_gpr_idx  = gpr_q[head_q];
            out_commit_value    = value_q[head_q];
            out_commit_has_nzcv = set_nzcv_q[head_q];
            out_commit_nzcv     = nzcv_q[head_q];
        end
    end

    always_comb begin
        out_rd_done  = 1'b0;
        out_rd_value = '0;
        if (rd_in_range && busy_q[in_rd_rob_index] && done_q[in_rd_rob_index]) begin
            out_rd_done  = 1'b1;
            out_rd_value = value_q[in_rd_rob_index];
        end
`ifdef ROB_WB_BYPASS_EN
        if (in_wb_valid && rd_in_range && (in_wb_rob_index == in_rd_rob_index)
            && busy_q[in_rd_rob_index]) begin
            out_rd_done  = 1'b1;
            out_rd_value = in_wb_value;
        end
`endif
    end

    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        set_nzcv_d = set_nzcv_q;
        gpr_d      = gpr_q;
        value_d    = value_q;
        nzcv_d     = nzcv_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (in_flush) begin
            busy_d     = '0;
            done_d     = '0;
            set_nzcv_d = '0;
            gpr_d      = '{default: '0};
            value_d    = '{default: '0};
            nzcv_d     = '{default: '0};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (alloc_fire) begin
                busy_d[tail_q]     = 1'b1;
                done_d[tail_q]     = 1'b0;
                gpr_d[tail_q]      = in_alloc_gpr_idx;
                set_nzcv_d[tail_q] = in_alloc_set_nzcv;
                tail_d             = wrap_inc(tail_q);
            end
            if (wb_ok) begin
                done_d[in_wb_rob_index]  = 1'b1;
                value_d[in_wb_rob_index] = in_wb_value;
                nzcv_d[in_wb_rob_index]  = in_wb_nzcv;
            end
            if (out_commit_valid) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = wrap_inc(head_q);
            end
            unique case ({alloc_fire, out_commit_valid})
                2'b10:   count_d = count_q + (ROB_IDX_SIZE + 1)'(1);
                2'b01:   count_d = count_q - (ROB_IDX_SIZE + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            busy_q     <= '0;
            done_q     <= '0;
            set_nzcv_q <= '0;
            gpr_q      <= '{default: '0};
            value_q    <= '{default: '0};
            nzcv_q     <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            set_nzcv_q <= set_nzcv_d;
            gpr_q      <= gpr_d;
            value_q    <= value_d;
            nzcv_q     <= nzcv_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

`ifndef SYNTHESIS
    // A writeback must target an allocated, not-yet-completed entry.
    always_ff @(posedge in_clk) begin
        if (!in_rst && !in_flush && in_wb_valid && wb_in_range) begin
            assert (busy_q[in_wb_rob_index] && !done_q[in_wb_rob_index])
            else $error("reorder_buffer: writeback to idle or completed tag %0d", in_wb_rob_index);
        end
    end
`endif

endmodule
